// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
// Requester indices double as the low ARID bits.
package axi_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  localparam int REQ_ICACHE  = 0;
  localparam int REQ_DCACHE  = 1;
  localparam int REQ_UNCACHE = 2;

  localparam logic [3:0] ARCACHE_DEFAULT = 4'hF;
  localparam logic [2:0] ARPROT_DEFAULT  = 3'b000;

endpackage

// File: rtl/axi_rd_arbiter_rr.sv
// rr_arbiter: one-hot grant plus index from a request vector.
// AXI_RD_ARB_RR_EN selects round-robin; otherwise lowest index wins.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [IW-1:0] adv_idx,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

`ifdef AXI_RD_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // ptr_q holds the index the next search starts from
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j -= N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (adv_idx == IW'(N - 1)) ptr_d = '0;
      else                       ptr_d = adv_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, reset, advance, adv_idx};

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 AR/R channel pair between ICache, DCache and UnCache.
// Define AXI_RD_ARB_RR_EN for round-robin, else fixed priority.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int N_MASTER = 3,
  parameter int MAX_OUT  = 2,
  parameter int ID_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_MASTER*32-1:0] s_araddr,
  input  logic [N_MASTER*8-1:0] s_arlen,
  input  logic [N_MASTER*3-1:0] s_arsize,
  input  logic [N_MASTER*2-1:0] s_arburst,
  input  logic [N_MASTER-1:0]   s_arvalid,
  output logic [N_MASTER-1:0]   s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic [N_MASTER-1:0]   s_rvalid,
  input  logic [N_MASTER-1:0]   s_rready,
  output logic [ID_W-1:0]       arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_W-1:0]       rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  rd_id_err
);

  localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

  arb_state_t state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] sel, win_idx, r_idx;
  logic [N_MASTER-1:0][2:0] out_cnt_q, out_cnt_d;
  logic err_q, err_d;
  logic [N_MASTER-1:0] elig, win_gnt, inc, dec;
  logic win_any, ar_hs, r_ok;
  logic unused_rid;

  assign unused_rid = ^rid[ID_W-1:IDX_W];

  // Eligibility uses this cycle's counters, before any update
  always_comb begin
    for (int i = 0; i < N_MASTER; i++) begin
      elig[i] = s_arvalid[i] && (out_cnt_q[i] < 3'(MAX_OUT));
    end
  end

  rr_arbiter #(
    .N  (N_MASTER),
    .IW (IDX_W)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (elig),
    .advance (ar_hs),
    .adv_idx (sel),
    .gnt     (win_gnt),
    .idx     (win_idx),
    .any     (win_any)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel       = win_idx;
    arvalid   = 1'b0;
    s_arready = '0;
    unique case (state_q)
      ARB_IDLE: begin
        arvalid = win_any;
        if (win_any) begin
          if (arready) begin
            s_arready = win_gnt;
          end else begin
            state_d = ARB_HOLD;
            grant_d = win_idx;
          end
        end
      end
      ARB_HOLD: begin
        sel     = grant_q;
        arvalid = 1'b1;
        if (arready) begin
          s_arready[grant_q] = 1'b1;
          state_d            = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (reset) begin
      arvalid   = 1'b0;
      s_arready = '0;
    end
  end

  assign ar_hs   = arvalid && arready;
  assign arid    = ID_W'(sel);
  assign araddr  = s_araddr[int'(sel)*32 +: 32];
  assign arlen   = s_arlen[int'(sel)*8 +: 8];
  assign arsize  = s_arsize[int'(sel)*3 +: 3];
  assign arburst = s_arburst[int'(sel)*2 +: 2];
  assign arlock  = 1'b0;
  assign arcache = ARCACHE_DEFAULT;
  assign arprot  = ARPROT_DEFAULT;

  assign r_idx   = rid[IDX_W-1:0];
  assign r_ok    = int'(r_idx) < N_MASTER;
  assign s_rdata = rdata;
  assign s_rresp = rresp;
  assign s_rlast = rlast;

  // Beats for an unknown requester are drained so the bus cannot stall
  always_comb begin
    s_rvalid = '0;
    rready   = 1'b1;
    dec      = '0;
    err_d    = err_q;
    if (r_ok) begin
      s_rvalid[r_idx] = rvalid;
      rready          = s_rready[r_idx];
      dec[r_idx]      = rvalid && s_rready[r_idx] && rlast;
    end else if (rvalid) begin
      err_d = 1'b1;
    end
    if (reset) s_rvalid = '0;
  end

  always_comb begin
    inc       = '0;
    out_cnt_d = out_cnt_q;
    for (int i = 0; i < N_MASTER; i++) begin
      inc[i] = ar_hs && (sel == IDX_W'(i));
      if (inc[i] && !dec[i]) begin
        out_cnt_d[i] = out_cnt_q[i] + 3'd1;
      end else if (dec[i] && !inc[i] && out_cnt_q[i] != 3'd0) begin
        out_cnt_d[i] = out_cnt_q[i] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  assign rd_id_err = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter; expectations are hand-computed.
// Build with or without AXI_RD_ARB_RR_EN.
module tb_axi_rd_arbiter;
  import axi_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [95:0] s_araddr;
  logic [23:0] s_arlen;
  logic [8:0]  s_arsize;
  logic [5:0]  s_arburst;
  logic [2:0]  s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_rdata, araddr, rdata;
  logic [1:0]  s_rresp, arburst, rresp;
  logic        s_rlast, arlock, arvalid, arready, rlast, rvalid;
  logic        rready, rd_id_err;
  logic [3:0]  arid, arcache, rid;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_seq [4];

  axi_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .arid(arid),
    .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid),
    .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .rd_id_err(rd_id_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_arvalid = '0;
    s_rready  = '0;
    arready   = 1'b0;
    rid       = '0;
    rdata     = '0;
    rresp     = '0;
    rlast     = 1'b0;
    rvalid    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_ar(input int i, input logic [31:0] a,
                        input logic [7:0] l);
    s_araddr[i*32 +: 32] = a;
    s_arlen[i*8 +: 8]    = l;
    s_arsize[i*3 +: 3]   = 3'd2;
    s_arburst[i*2 +: 2]  = 2'd1;
  endtask

  // Counter must never be pushed past MAX_OUT
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (s_arready[i] && !(s_rvalid[i] && s_rready[i] && rlast)
            && dut.out_cnt_q[i] == 3'd2)
          chk("inc_at_max", 64'd1, 64'd0);
        if (s_rvalid[i] && s_rready[i] && rlast && !s_arready[i]
            && dut.out_cnt_q[i] == 3'd0)
          chk("dec_at_zero", 64'd1, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
`ifdef AXI_RD_ARB_RR_EN
    exp_seq[0] = 4'd0; exp_seq[1] = 4'd1;
    exp_seq[2] = 4'd2; exp_seq[3] = 4'd0;
`else
    exp_seq[0] = 4'd0; exp_seq[1] = 4'd0;
    exp_seq[2] = 4'd1; exp_seq[3] = 4'd1;
`endif
    reset = 1'b1;
    clr();
    tick();
    s_arvalid = 3'b111;
    arready   = 1'b1;
    #2;
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_s_arready", 64'(s_arready), 64'd0);
    tick();
    chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_err", 64'(rd_id_err), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(ARB_IDLE));
    chk("rst_cnt", 64'(dut.out_cnt_q), 64'd0);
    clr();
    reset = 1'b0;
    tick();

    // DCache single burst
    set_ar(1, 32'h1000, 8'd3);
    s_arvalid = 3'b010;
    arready   = 1'b1;
    #2;
    chk("t1_arvalid", 64'(arvalid), 64'd1);
    chk("t1_arid", 64'(arid), 64'd1);
    chk("t1_araddr", 64'(araddr), 64'h1000);
    chk("t1_arlen", 64'(arlen), 64'd3);
    chk("t1_arcache", 64'(arcache), 64'hF);
    chk("t1_s_arready", 64'(s_arready), 64'b010);
    tick();
    s_arvalid = '0;
    arready   = 1'b0;
    chk("t1_cnt_inc", 64'(dut.out_cnt_q[1]), 64'd1);
    for (int b = 0; b < 4; b++) begin
      rvalid   = 1'b1;
      rid      = 4'd1;
      rdata    = 32'hA0 + 32'(b);
      rlast    = (b == 3);
      s_rready = 3'b010;
      #2;
      chk("t1_s_rvalid", 64'(s_rvalid), 64'b010);
      chk("t1_rready", 64'(rready), 64'd1);
      chk("t1_rdata", 64'(s_rdata), 64'(32'hA0 + 32'(b)));
      tick();
    end
    clr();
    chk("t1_cnt_dec", 64'(dut.out_cnt_q[1]), 64'd0);
    do_reset();

    // ICache and UnCache with arready low for 3 cycles
    set_ar(0, 32'h2000, 8'd7);
    set_ar(2, 32'h3000, 8'd1);
    s_arvalid = 3'b101;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("t2_arid", 64'(arid), 64'd0);
      chk("t2_araddr", 64'(araddr), 64'h2000);
      chk("t2_arvalid", 64'(arvalid), 64'd1);
      chk("t2_no_ready", 64'(s_arready), 64'd0);
      tick();
      chk("t2_hold", 64'(dut.state_q), 64'(ARB_HOLD));
    end
    arready = 1'b1;
    #2;
    chk("t2_hs", 64'(s_arready), 64'b001);
    chk("t2_hs_arid", 64'(arid), 64'd0);
    tick();
    chk("t2_idle", 64'(dut.state_q), 64'(ARB_IDLE));
    s_arvalid = 3'b100;
    #2;
    chk("t2_next_arid", 64'(arid), 64'd2);
    chk("t2_next_rdy", 64'(s_arready), 64'b100);
    tick();
    arready = 1'b0;
    tick();
    chk("t2b_hold", 64'(dut.state_q), 64'(ARB_HOLD));
    reset = 1'b1;
    #2;
    chk("t2b_rst_arvalid", 64'(arvalid), 64'd0);
    tick();
    reset     = 1'b0;
    s_arvalid = '0;
    chk("t2b_rst_state", 64'(dut.state_q), 64'(ARB_IDLE));
    chk("t2b_rst_cnt", 64'(dut.out_cnt_q[2]), 64'd0);
    do_reset();

    // All three requesting back to back
    set_ar(0, 32'h4000, 8'd0);
    set_ar(1, 32'h5000, 8'd0);
    set_ar(2, 32'h6000, 8'd0);
    s_arvalid = 3'b111;
    arready   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("t3_seq", 64'(arid), 64'(exp_seq[c]));
      tick();
    end
    do_reset();

    // UnCache hits MAX_OUT, then frees one
    set_ar(2, 32'h7000, 8'd0);
    s_arvalid = 3'b100;
    arready   = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("t4_issue", 64'(s_arready), 64'b100);
      tick();
    end
    #2;
    chk("t4_masked", 64'(arvalid), 64'd0);
    chk("t4_masked_rdy", 64'(s_arready), 64'd0);
    chk("t4_cnt_max", 64'(dut.out_cnt_q[2]), 64'd2);
    rvalid   = 1'b1;
    rid      = 4'd2;
    rlast    = 1'b1;
    s_rready = 3'b100;
    #2;
    chk("t4_still_masked", 64'(arvalid), 64'd0);
    chk("t4_s_rvalid", 64'(s_rvalid), 64'b100);
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk("t4_cnt_freed", 64'(dut.out_cnt_q[2]), 64'd1);
    #2;
    chk("t4_regrant", 64'(arvalid), 64'd1);
    chk("t4_regrant_id", 64'(arid), 64'd2);
    chk("t4_regrant_rdy", 64'(s_arready), 64'b100);
    tick();
    chk("t4_cnt_again", 64'(dut.out_cnt_q[2]), 64'd2);
    do_reset();

    // Same-cycle increment and decrement for DCache
    set_ar(1, 32'h8000, 8'd0);
    s_arvalid = 3'b010;
    arready   = 1'b1;
    #2;
    tick();
    chk("t5_cnt1", 64'(dut.out_cnt_q[1]), 64'd1);
    rvalid   = 1'b1;
    rid      = 4'd1;
    rlast    = 1'b1;
    s_rready = 3'b010;
    #2;
    chk("t5_ar", 64'(s_arready), 64'b010);
    chk("t5_r", 64'(s_rvalid), 64'b010);
    tick();
    clr();
    chk("t5_cnt_same", 64'(dut.out_cnt_q[1]), 64'd1);
    do_reset();

    // Unknown RID
    rvalid   = 1'b1;
    rid      = 4'd3;
    s_rready = 3'b000;
    #2;
    chk("t6_rready", 64'(rready), 64'd1);
    chk("t6_s_rvalid", 64'(s_rvalid), 64'd0);
    tick();
    rvalid = 1'b0;
    chk("t6_err_set", 64'(rd_id_err), 64'd1);
    tick();
    chk("t6_err_sticky", 64'(rd_id_err), 64'd1);
    do_reset();
    chk("t6_err_clr", 64'(rd_id_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
